ram_bus_arbiter: RTL and testbench
==================================

Name: ram_bus_arbiter

Overview:
N-master, single-RAM bus arbiter with round-robin fairness and parametrised data, address and RAM read-latency.
- Sits between the N core memory ports and the shared RAM. It serialises read and write transactions from the cores.
- Successor to the fixed two-core bus. Adds a per-transaction grant/done handshake, a configurable master count and a multi-cycle read path.

Parameters:
N_MASTERS, 2, number of requesting cores (range 2..8)
ADDR_W, 9, RAM address width
DATA_W, 8, RAM data width
RD_LAT, 1, RAM read latency in cycles from registered address to valid ram_data_out (range 1..4)

Ports:
clk  in  1  single clock; all state changes on posedge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  N_MASTERS  per-master request; held high until that master's done pulse
req_rw  in  N_MASTERS  per-master type: 0 = write, 1 = read
req_addr  in  N_MASTERS*ADDR_W  per-master address; master i occupies slice [i*ADDR_W +: ADDR_W]
req_wdata  in  N_MASTERS*DATA_W  per-master write data, same slicing scheme
grant  out  N_MASTERS  one-hot; high while that master's transaction is in flight
done  out  N_MASTERS  one-cycle pulse marking transaction completion
rdata  out  N_MASTERS*DATA_W  per-master read-data register; updated only on that master's read completion
ram_addr  out  ADDR_W  RAM address, registered
ram_data_in  out  DATA_W  RAM write data, registered
ram_data_out  in  DATA_W  RAM read data
ram_we  out  1  RAM write enable, 1 = write; registered

Behaviour:
- Reset (reset=0, takes effect immediately without waiting for a clock edge):
  - Control outputs: grant=0, done=0, ram_we=0.
  - Data outputs: ram_addr=0, ram_data_in=0, rdata=0.
  - Internal state: state=IDLE, last=N_MASTERS-1, so master 0 wins the first arbitration.
  - Reset mid-transaction aborts the transaction with no done pulse. ram_we drops at once.
- Eligible masters: eligible = req & ~done. This masks any master being completed this cycle, so a held-over request is never served twice.
- Arbitration: winner = first eligible index scanning last+1, last+2, … modulo N_MASTERS.
- States:
  - IDLE, with eligible≠0 (edge E1):
    - Latch winner index; set last<=winner; grant[winner]<=1.
    - ram_addr <= winner's address.
    - Write: ram_data_in <= winner's wdata, ram_we<=1, go to WR.
    - Read: ram_we<=0, lat_cnt<=1, go to RD.
  - IDLE, with eligible=0: stay in IDLE; all outputs hold except done, which clears.
  - WR (edge E2): ram_we<=0, grant<=0, done[idx]<=1, go to IDLE. ram_we is high for exactly one cycle.
  - RD:
    - If lat_cnt==RD_LAT: rdata[idx] <= ram_data_out, grant<=0, done[idx]<=1, go to IDLE.
    - Otherwise lat_cnt<=lat_cnt+1.
- Latency, counted from request sampled at E1 to done high:
  - Write: 1 cycle after grant.
  - Read: RD_LAT cycles after grant.
- Back-to-back transactions: one IDLE cycle separates any two transactions. The IDLE cycle coincides with the done pulse.
- Stable inputs: the arbiter latches only the index. The master must hold req_rw, req_addr and req_wdata stable while grant is high.
- Ignored requests: req dropped while granted is ignored, and the transaction completes anyway.
- Simultaneous requests: resolved purely by the round-robin pointer. No master waits more than N_MASTERS-1 transactions.
- ram_addr and ram_data_in hold their last values in IDLE. The RAM must qualify on ram_we only.

Decomposition:
- Package bus_pkg:
  - state enum {IDLE, WR, RD}.
  - Constants RW_WRITE=0, RW_READ=1.
  - Width helper function clog2 for the index and lat_cnt.
- Sub-module rr_arbiter (combinational):
  - Inputs: eligible, last.
  - Outputs: winner index and any_valid.
  - Parametrised by N_MASTERS.
  - Unit-tested separately.

Test Plan:
- Reset: hold reset=0 with req all 1 -> grant=0, done=0, ram_we=0. First grant after release goes to master 0.
- Single write: N=2, master 1 writes addr 0x1A5, data 0x3C.
  - Next edge: grant=2'b10, ram_we=1, ram_addr=0x1A5, ram_data_in=0x3C.
  - Following edge: done=2'b10, ram_we=0.
- Single read with RD_LAT=3: RAM model returns 0x77 at addr 0x010.
  - done[0] arrives exactly 3 cycles after grant[0] rises.
  - rdata[0]=0x77; rdata[1] is unchanged.
- Contention: N=4, all masters request continuously -> grant order 0,1,2,3,0,… with each master served once per 4 transactions.
- Held-over request: master drops req one cycle after done -> no second transaction is issued for that master.
- Async reset mid-read: assert reset=0 during RD -> grant=0 and done=0 immediately, with no rdata update. Next arbitration starts from master 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the RAM bus arbiter: FSM state encoding,
// transaction type constants and a width helper.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Bits needed to encode values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index after i_last,
// wrapping modulo N_MASTERS.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    localparam int IDX_W = clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] i_eligible,
    input  logic [IDX_W-1:0]     i_last,
    output logic [IDX_W-1:0]     o_winner,
    output logic                 o_any_valid
);

    // Scan from the farthest candidate to the nearest so the nearest one
    // after i_last overwrites the others.
    always_comb begin
        o_winner = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            if (i_eligible[IDX_W'((int'(i_last) + k) % N_MASTERS)]) begin
                o_winner = IDX_W'((int'(i_last) + k) % N_MASTERS);
            end
        end
    end

    assign o_any_valid = |i_eligible;

endmodule

// File: rtl/ram_bus_arbiter.sv
// N-master round-robin arbiter in front of a single RAM; serialises write
// (one cycle) and read (RD_LAT cycles) transactions with grant/done handshake.
module ram_bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          req,
    input  logic [N_MASTERS-1:0]          req_rw,
    input  logic [N_MASTERS*ADDR_W-1:0]   req_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   req_wdata,
    output logic [N_MASTERS-1:0]          grant,
    output logic [N_MASTERS-1:0]          done,
    output logic [N_MASTERS*DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_data_in,
    input  logic [DATA_W-1:0]             ram_data_out,
    output logic                          ram_we
);

    localparam int IDX_W = clog2(N_MASTERS);
    localparam int LAT_W = clog2(RD_LAT + 1);

    state_t                        r_state;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              r_last;
    logic [LAT_W-1:0]              r_lat_cnt;
    logic [N_MASTERS-1:0]          r_grant;
    logic [N_MASTERS-1:0]          r_done;
    logic [N_MASTERS*DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]             r_ram_addr;
    logic [DATA_W-1:0]             r_ram_data_in;
    logic                          r_ram_we;

    logic [N_MASTERS-1:0]          w_eligible;
    logic [IDX_W-1:0]              w_winner;
    logic                          w_any_valid;

    // A master whose done is high this cycle still holds req; mask it so it
    // is not served a second time.
    assign w_eligible = req & ~r_done;

    rr_arbiter #(
        .N_MASTERS (N_MASTERS)
    ) u_rr_arbiter (
        .i_eligible  (w_eligible),
        .i_last      (r_last),
        .o_winner    (w_winner),
        .o_any_valid (w_any_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_last        <= IDX_W'(N_MASTERS - 1);
            r_lat_cnt     <= '0;
            r_grant       <= '0;
            r_done        <= '0;
            r_rdata       <= '0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
            r_ram_we      <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_idx      <= w_winner;
                        r_last     <= w_winner;
                        r_grant    <= N_MASTERS'(1) << w_winner;
                        r_ram_addr <= req_addr[w_winner*ADDR_W +: ADDR_W];
                        if (req_rw[w_winner] == RW_WRITE) begin
                            r_ram_data_in <= req_wdata[w_winner*DATA_W +: DATA_W];
                            r_ram_we      <= 1'b1;
                            r_state       <= WR;
                        end else begin
                            r_ram_we  <= 1'b0;
                            r_lat_cnt <= LAT_W'(1);
                            r_state   <= RD;
                        end
                    end
                end
                WR: begin
                    r_ram_we      <= 1'b0;
                    r_grant       <= '0;
                    r_done[r_idx] <= 1'b1;
                    r_state       <= IDLE;
                end
                RD: begin
                    if (r_lat_cnt == LAT_W'(RD_LAT)) begin
                        r_rdata[r_idx*DATA_W +: DATA_W] <= ram_data_out;
                        r_grant       <= '0;
                        r_done[r_idx] <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign ram_addr    = r_ram_addr;
    assign ram_data_in = r_ram_data_in;
    assign ram_we      = r_ram_we;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter (4 masters, read latency 3):
// directed vectors, reset corner cases and random traffic vs a schedule model.
module tb_ram_bus_arbiter;

    localparam int N   = 4;
    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      req_rw;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      grant;
    logic [N-1:0]      done;
    logic [N*DW-1:0]   rdata;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_data_in;
    logic [DW-1:0]     ram_data_out;
    logic              ram_we;

    always #5 clk = ~clk;

    ram_bus_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .grant        (grant),
        .done         (done),
        .rdata        (rdata),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .ram_we       (ram_we)
    );

    // RAM model: data for an address is valid LAT cycles after ram_addr is registered
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] a_d1, a_d2;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    initial for (int a = 0; a < 2**AW; a++) mem[a] = dflt(AW'(a));

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        a_d1 <= ram_addr;
        a_d2 <= a_d1;
    end
    assign ram_data_out = mem[a_d2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_master(input int m, input logic r, input logic rw,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[m]                = r;
        req_rw[m]             = rw;
        req_addr[m*AW +: AW]  = a;
        req_wdata[m*DW +: DW] = d;
    endtask

    typedef struct {
        int           m;
        logic         rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [N-1:0] exp_grant;
        int           exp_lat;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [7];

    task automatic run_vec(input vec_t v);
        int n, l;
        logic [N*DW-1:0] prev, mask;
        @(negedge clk);
        set_master(v.m, 1'b1, v.rw, v.addr, v.wd);
        prev = rdata;
        mask = '0;
        if (v.rw) mask[v.m*DW +: DW] = '1;
        n = 0;
        do begin @(negedge clk); n++; end while (grant[v.m] !== 1'b1 && n < 10);
        check("vec_grant", 64'(grant), 64'(v.exp_grant));
        check("vec_ram_addr", 64'(ram_addr), 64'(v.addr));
        check("vec_ram_we", 64'(ram_we), 64'(!v.rw));
        if (!v.rw) check("vec_ram_data_in", 64'(ram_data_in), 64'(v.wd));
        l = 0;
        do begin @(negedge clk); l++; end while (done[v.m] !== 1'b1 && l < 10);
        check("vec_latency", 64'(l), 64'(v.exp_lat));
        check("vec_done", 64'(done), 64'(v.exp_grant));
        check("vec_grant_off", 64'(grant), 64'(0));
        check("vec_ram_we_off", 64'(ram_we), 64'(0));
        if (v.rw) check("vec_rdata", 64'(rdata[v.m*DW +: DW]), 64'(v.exp_rd));
        check("vec_rdata_others", 64'(rdata & ~mask), 64'(prev & ~mask));
        // req is still high during the done cycle; it must not be re-served
        @(negedge clk);
        check("vec_holdover_grant", 64'(grant), 64'(0));
        check("vec_holdover_done", 64'(done), 64'(0));
        req[v.m] = 1'b0;
        @(negedge clk);
        check("vec_idle_grant", 64'(grant), 64'(0));
    endtask

    // Transaction-level reference model for the random phase
    logic [DW-1:0]   shadow [2**AW];
    logic            m_busy;
    int              m_end, m_who, m_last;
    logic            m_rw;
    logic [AW-1:0]   m_addr;
    logic [N-1:0]    exp_grant, exp_done;
    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_din;
    logic [N*DW-1:0] exp_rdata;
    int              mst [N];

    task automatic model_step(input int c);
        logic [N-1:0] pd, elig;
        int w, j;
        pd = exp_done;
        exp_done = '0;
        if (m_busy) begin
            if (c == m_end) begin
                exp_done[m_who] = 1'b1;
                exp_grant = '0;
                exp_we = 1'b0;
                m_busy = 1'b0;
                if (m_rw) exp_rdata[m_who*DW +: DW] = shadow[m_addr];
            end
        end else begin
            elig = req & ~pd;
            if (elig != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (w < 0 && elig[j]) w = j;
                end
                m_last = w;
                m_who  = w;
                m_busy = 1'b1;
                m_rw   = req_rw[w];
                m_addr = req_addr[w*AW +: AW];
                m_end  = c + (m_rw ? LAT : 1);
                exp_grant = '0;
                exp_grant[w] = 1'b1;
                exp_addr = m_addr;
                if (!m_rw) begin
                    exp_din = req_wdata[w*DW +: DW];
                    exp_we  = 1'b1;
                    shadow[m_addr] = exp_din;
                end else begin
                    exp_we = 1'b0;
                end
            end
        end
    endtask

    task automatic new_req(input int i);
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15)) | (AW'($urandom_range(0, 1)) << 8);
        set_master(i, 1'b1, 1'($urandom_range(0, 1)), a, DW'($urandom_range(0, 255)));
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            case (mst[i])
                0: if ($urandom_range(0, 3) == 0) begin new_req(i); mst[i] = 1; end
                1: if (done[i] === 1'b1) mst[i] = 2;
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        new_req(i);
                        mst[i] = 1;
                    end else begin
                        req[i] = 1'b0;
                        mst[i] = 0;
                    end
                end
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [N-1:0] exp_g;

        tbl[0] = '{1, 1'b0, 9'h1A5, 8'h3C, 4'b0010, 1, 8'h00};
        tbl[1] = '{2, 1'b0, 9'h010, 8'h77, 4'b0100, 1, 8'h00};
        tbl[2] = '{0, 1'b1, 9'h010, 8'h00, 4'b0001, 3, 8'h77};
        tbl[3] = '{3, 1'b1, 9'h1A5, 8'h00, 4'b1000, 3, 8'h3C};
        tbl[4] = '{2, 1'b0, 9'h100, 8'hC3, 4'b0100, 1, 8'h00};
        tbl[5] = '{1, 1'b1, 9'h000, 8'h00, 4'b0010, 3, 8'h5A};
        tbl[6] = '{0, 1'b1, 9'h100, 8'h00, 4'b0001, 3, 8'hC3};

        // Reset held with every master requesting
        reset = 1'b0;
        req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        for (int m = 0; m < N; m++)
            set_master(m, 1'b1, 1'(m % 2), AW'(9'h040 + m - (m % 2)), DW'(8'h90 + m));
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ram_we", 64'(ram_we), 64'(0));
        check("rst_ram_addr", 64'(ram_addr), 64'(0));
        check("rst_ram_data_in", 64'(ram_data_in), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));

        // Release with continuous contention: order must be 0,1,2,3,0,...
        reset = 1'b1;
        for (int t = 0; t < 8; t++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (grant === '0 && n < 10);
            exp_g = N'(1) << (t % N);
            check("contention_order", 64'(grant), 64'(exp_g));
            n = 0;
            do begin @(negedge clk); n++; end while (grant !== '0 && n < 10);
            check("contention_done", 64'(done), 64'(exp_g));
        end
        req = '0;
        repeat (LAT + 2) @(negedge clk);
        check("contention_drain", 64'(grant), 64'(0));

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Reset in the middle of a write drops ram_we without a clock edge
        @(negedge clk);
        set_master(1, 1'b1, 1'b0, 9'h055, 8'hEE);
        n = 0;
        do begin @(negedge clk); n++; end while (grant[1] !== 1'b1 && n < 10);
        check("midwr_ram_we_before", 64'(ram_we), 64'(1));
        #1 reset = 1'b0;
        #1;
        check("midwr_ram_we", 64'(ram_we), 64'(0));
        check("midwr_grant", 64'(grant), 64'(0));
        req = '0;
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of a read: no done, no rdata update
        set_master(2, 1'b1, 1'b1, 9'h010, 8'h00);
        n = 0;
        do begin @(negedge clk); n++; end while (grant[2] !== 1'b1 && n < 10);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrd_grant", 64'(grant), 64'(0));
        check("midrd_done", 64'(done), 64'(0));
        check("midrd_rdata", 64'(rdata), 64'(0));
        req = '0;
        @(negedge clk);
        // Pointer restarts: with masters 2 and 3 requesting, 2 wins
        reset = 1'b1;
        set_master(2, 1'b1, 1'b1, 9'h010, 8'h00);
        set_master(3, 1'b1, 1'b0, 9'h011, 8'h11);
        @(negedge clk);
        check("post_rst_winner", 64'(grant), 64'(4'b0100));
        // Dropping req while granted: the read still completes
        req = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (done[2] !== 1'b1 && n < 10);
        check("dropped_req_latency", 64'(n), 64'(LAT));
        check("dropped_req_rdata", 64'(rdata[2*DW +: DW]), 64'(8'h77));
        repeat (2) @(negedge clk);
        check("dropped_req_idle", 64'(grant), 64'(0));

        // Random traffic against the schedule model
        reset = 1'b0;
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 2**AW; a++) shadow[a] = mem[a];
        m_busy = 1'b0; m_last = N - 1; m_end = 0; m_who = 0; m_rw = 1'b0; m_addr = '0;
        exp_grant = '0; exp_done = '0; exp_we = 1'b0;
        exp_addr = '0; exp_din = '0; exp_rdata = '0;
        for (int i = 0; i < N; i++) mst[i] = 0;
        drive_masters();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            model_step(c);
            @(negedge clk);
            check("rnd_grant", 64'(grant), 64'(exp_grant));
            check("rnd_done", 64'(done), 64'(exp_done));
            check("rnd_ram_we", 64'(ram_we), 64'(exp_we));
            check("rnd_ram_addr", 64'(ram_addr), 64'(exp_addr));
            check("rnd_ram_data_in", 64'(ram_data_in), 64'(exp_din));
            check("rnd_rdata", 64'(rdata), 64'(exp_rdata));
            drive_masters();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
